// File: rtl/dclab_key_pkg.sv
// Shared types and constants for the push-button conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dclab_key_pkg;

    localparam int CNT_W            = 26;
    localparam int DEBOUNCE_CYC_DEF = 500000;    // 10 ms at 50 MHz
    localparam int LONG_CYC_DEF     = 50000000;  // 1 s at 50 MHz

    typedef enum logic [1:0] {
        S_UP      = 2'd0,
        S_DN_WAIT = 2'd1,
        S_DOWN    = 2'd2,
        S_UP_WAIT = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM, hold timer, registered pulses.
// Latency: press/release pulse DEBOUNCE_CYC+3 edges after a stable raw transition.
// Backpressure: none; pulses are single-cycle strobes the consumer must catch.
module key_debounce_ch
    import dclab_key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC     = LONG_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_press,
    output logic o_release,
    output logic o_level,
    output logic o_long
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(LONG_CYC);

    logic             sync1_q, sync2_q;
    logic             pressed;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             level_q, level_d;
    logic             long_q, long_d;

    // Bring the raw button level into the clock domain; idle (released) is 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_key;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ~sync2_q;

    // State, counters and the registered output strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_UP;
            deb_q     <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            level_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
            level_q   <= level_d;
            long_q    <= long_d;
        end
    end

    // Next-state: debounce each edge separately; the hold timer keeps running
    // while a release is still being qualified so a rejected release glitch
    // does not shift the long-press point. Saturation makes o_long one-shot.
    always_comb begin
        state_d   = state_q;
        deb_d     = deb_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        if (state_q == S_DOWN || state_q == S_UP_WAIT) begin
            if (hold_q == LONG_LAST) long_d = 1'b1;
            if (hold_q < HOLD_MAX)   hold_d = hold_q + CNT_W'(1);
        end

        case (state_q)
            S_UP: begin
                if (pressed) begin
                    state_d = S_DN_WAIT;
                    deb_d   = '0;
                end
            end
            S_DN_WAIT: begin
                if (!pressed) begin
                    state_d = S_UP;
                end else if (deb_q == DEB_LAST) begin
                    state_d = S_DOWN;
                    press_d = 1'b1;
                    hold_d  = '0;
                end else begin
                    deb_d = deb_q + CNT_W'(1);
                end
            end
            S_DOWN: begin
                if (!pressed) begin
                    state_d = S_UP_WAIT;
                    deb_d   = '0;
                end
            end
            S_UP_WAIT: begin
                if (pressed) begin
                    state_d = S_DOWN;
                end else if (deb_q == DEB_LAST) begin
                    state_d   = S_UP;
                    release_d = 1'b1;
                end else begin
                    deb_d = deb_q + CNT_W'(1);
                end
            end
            default: state_d = S_UP;
        endcase

        level_d = (state_d == S_DOWN) || (state_d == S_UP_WAIT);
    end

    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_level   = level_q;
    assign o_long    = long_q;

endmodule

// File: rtl/key_conditioner.sv
// Debounced press/release/long-press strobes for N_KEYS independent active-low buttons.
// Latency: DEBOUNCE_CYC+3 edges from a stable raw edge to the press/release strobe.
// Backpressure: none; all outputs are registered single-cycle strobes or levels.
module key_conditioner
    import dclab_key_pkg::*;
#(
    parameter int N_KEYS       = 3,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int LONG_CYC     = LONG_CYC_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_key,
    output logic [N_KEYS-1:0] o_press,
    output logic [N_KEYS-1:0] o_release,
    output logic [N_KEYS-1:0] o_level,
    output logic [N_KEYS-1:0] o_long
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_key     (i_key[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_level   (o_level[g]),
            .o_long    (o_long[g])
        );
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 SHALL have parameter N_KEYS, 3, number of independent key channels (bit 0 = start, bit 1 = left, bit 2 = right).
REQ-002 SHALL have parameter DEBOUNCE_CYC, 500000, stable-level cycles required to accept a transition (10 ms at 50 MHz); legal range 2..2^26-1.
REQ-003 SHALL have parameter LONG_CYC, 50000000, debounced-hold cycles before a long-press pulse (1 s at 50 MHz); legal range 2..2^26-1.
REQ-004 SHALL have port i_clk  input  1  system clock, 50 MHz.
REQ-005 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_key  input  N_KEYS  raw push-button levels, active-low (0 = pressed), asynchronous to i_clk.
REQ-007 SHALL have port o_press  output  N_KEYS  one-cycle pulse per accepted press.
REQ-008 SHALL have port o_release  output  N_KEYS  one-cycle pulse per accepted release.
REQ-009 SHALL have port o_level  output  N_KEYS  debounced level, 1 = pressed.
REQ-010 SHALL have port o_long  output  N_KEYS  one-cycle pulse once per hold reaching LONG_CYC.

Function
REQ-011 Each channel SHALL be fully independent; simultaneous activity on several keys SHALL NOT interact.
REQ-012 Each i_key bit SHALL pass a 2-flop synchronizer; the synchronized value, inverted, is "pressed".
REQ-013 Each channel SHALL run FSM states S_UP, S_DN_WAIT, S_DOWN, S_UP_WAIT with one 26-bit debounce counter and one 26-bit hold counter.
REQ-014 S_UP: pressed -> S_DN_WAIT, debounce counter cleared; else stay.
REQ-015 S_DN_WAIT: not pressed -> S_UP, no output (bounce rejected); counter == DEBOUNCE_CYC-1 -> S_DOWN, o_press pulse, hold counter cleared; else counter +1.
REQ-016 S_DOWN: not pressed -> S_UP_WAIT, debounce counter cleared; hold counter +1, saturating at LONG_CYC.
REQ-017 o_long SHALL pulse exactly once per hold, in the cycle after the hold counter reaches LONG_CYC-1; no repeat while held.
REQ-018 S_UP_WAIT: pressed -> S_DOWN, no output, hold counter NOT cleared; counter == DEBOUNCE_CYC-1 -> S_UP, o_release pulse; else counter +1.
REQ-019 o_level SHALL be 1 exactly in S_DOWN and S_UP_WAIT.
REQ-020 All outputs SHALL be registered; o_press SHALL rise DEBOUNCE_CYC+3 rising edges after (and counting) the first edge sampling i_key low, given i_key is stable.
REQ-021 o_press and o_release on one channel SHALL never be high in the same cycle; any two of them on the same channel SHALL be separated by at least DEBOUNCE_CYC cycles.
REQ-022 Glitches shorter than DEBOUNCE_CYC cycles (after synchronization) SHALL produce no pulse and no o_level change.

Reset
REQ-023 Reset SHALL force: synchronizer flops to 1, all FSMs to S_UP, all counters to 0, o_press/o_release/o_long/o_level to 0.
REQ-024 Reset asserted mid-operation SHALL abort any channel immediately with no pulse emitted.
REQ-025 A key held through reset deassertion SHALL be treated as a new press (S_DN_WAIT path, o_press issued).

Structure
REQ-026 Package dclab_key_pkg SHALL hold the channel-state enum, CNT_W = 26 and the default DEBOUNCE_CYC/LONG_CYC constants.
REQ-027 One sub-module key_debounce_ch (synchronizer, FSM, counters for a single key) SHALL be instantiated N_KEYS times by a generate loop.
REQ-028 No combinational path SHALL exist from i_key to any output.

Verification (DEBOUNCE_CYC=4, LONG_CYC=10)
REQ-029 Clean press: i_key[0] 1->0 held -> o_press[0] high for 1 cycle at edge 7, o_level[0]=1 from then on.
REQ-030 Bounce: i_key[1] low 3 cycles, high 2, low held -> exactly one o_press[1] pulse, 7 edges after the last falling transition.
REQ-031 Long press: key 2 held 30 cycles -> one o_long[2] pulse, 10 cycles after o_press[2]; release -> o_release[2] 7 edges after i_key rises.
REQ-032 Release glitch: during hold i_key high 2 cycles -> no o_release, o_level stays 1, o_long timing unchanged.
REQ-033 Simultaneous: all three keys pressed same cycle -> o_press=3'b111 in one cycle.
REQ-034 Reset mid-debounce, key still held -> all outputs 0 during reset; o_press issued 7 edges after i_rst_n deasserts.
